// File: rtl/sincronizador_antirrebote.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_antirrebote
// Brief    : Multi-channel synchroniser and debouncer for asynchronous
//            board inputs. Each channel passes through an N_ETAPAS
//            flip-flop chain into the clk domain. A debounce counter then
//            accepts a new level only after it has persisted for
//            DEBOUNCE_CICLOS consecutive cycles.
//            Optional one-cycle edge pulses are built when the macro
//            SINCRONIZADOR_PULSOS_EN is defined. Without the macro,
//            pulso_subida and pulso_bajada are tied to 0.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module sincronizador_antirrebote #(
   parameter int N_CANALES       = 4,
   parameter int N_ETAPAS        = 3,
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_CANALES-1:0] entrada_asincronica,
   output logic [N_CANALES-1:0] salida_estable,
   output logic [N_CANALES-1:0] pulso_subida,
   output logic [N_CANALES-1:0] pulso_bajada
);

   // Counter wide enough to hold DEBOUNCE_CICLOS-1, with one spare bit so
   // that DEBOUNCE_CICLOS=1 still gets a legal 1-bit counter.
   localparam int CNT_W = $clog2(DEBOUNCE_CICLOS) + 1;

   // Terminal count. When the counter sits here and the level still
   // differs, the new level is accepted.
   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CICLOS - 1);

   // Reject configurations that cannot synchronise or debounce.
   if (N_ETAPAS < 2 || DEBOUNCE_CICLOS < 1) begin : g_param_check
      $error("sincronizador_antirrebote: N_ETAPAS must be >= 2 and DEBOUNCE_CICLOS >= 1");
   end

   // Per-channel combinational debounce results, gathered into vectors.
   logic [N_CANALES-1:0] w_acepta;
   logic [N_CANALES-1:0] w_sync_q;

   for (genvar i = 0; i < N_CANALES; i++) begin : g_canal

      logic [N_ETAPAS-1:0] r_sync;
      logic [CNT_W-1:0]    r_cnt;
      logic                r_estable;
      logic                w_difiere;
      logic [CNT_W-1:0]    w_cnt_next;

      // Synchroniser chain: stage 0 captures the raw pin, and each later
      // stage copies the previous one.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_sync <= '0;
         end else begin
            r_sync <= {r_sync[N_ETAPAS-2:0], entrada_asincronica[i]};
         end
      end

      assign w_sync_q[i] = r_sync[N_ETAPAS-1];
      assign w_difiere   = w_sync_q[i] ^ r_estable;

      // Acceptance happens on the cycle that would otherwise push the
      // counter past its terminal count.
      assign w_acepta[i] = w_difiere && (r_cnt == c_cnt_max);

      // Next counter value. The counter restarts whenever the synchronised
      // level agrees with the accepted level, or when a change is accepted.
      always_comb begin
         w_cnt_next = '0;
         if (w_difiere && !w_acepta[i]) begin
            w_cnt_next = r_cnt + CNT_W'(1);
         end
      end

      // Debounce state: counter and accepted level. Reset discards any
      // partial count.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt     <= '0;
            r_estable <= 1'b0;
         end else begin
            r_cnt <= w_cnt_next;
            if (w_acepta[i]) begin
               r_estable <= w_sync_q[i];
            end
         end
      end

      assign salida_estable[i] = r_estable;

`ifdef SINCRONIZADOR_PULSOS_EN
      logic r_pulso_sub;
      logic r_pulso_baj;

      // Edge pulses: registered on the same edge that updates r_estable,
      // so each pulse lines up with the new output level. Only one of the
      // two can be set, because the accepted level is either 1 or 0.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_pulso_sub <= 1'b0;
            r_pulso_baj <= 1'b0;
         end else begin
            r_pulso_sub <= w_acepta[i] &  w_sync_q[i];
            r_pulso_baj <= w_acepta[i] & ~w_sync_q[i];
         end
      end

      assign pulso_subida[i] = r_pulso_sub;
      assign pulso_bajada[i] = r_pulso_baj;
`else
      // Pulses disabled: no pulse registers exist, and the outputs are held
      // low.
      assign pulso_subida[i] = 1'b0;
      assign pulso_bajada[i] = 1'b0;
`endif

   end : g_canal

endmodule : sincronizador_antirrebote
`default_nettype wire

// File: tb/tb_sincronizador_antirrebote.sv
`default_nettype none
// ============================================================================
// Module   : tb_sincronizador_antirrebote
// Brief    : Directed bench for sincronizador_antirrebote with 4 channels,
//            3 sync stages and a 4-cycle debounce. A queue-based reference
//            model is checked against the DUT on every negedge. Literal
//            expectations pin the key latencies.
//            Pulse expectations follow SINCRONIZADOR_PULSOS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sincronizador_antirrebote;

   localparam int NC  = 4;
   localparam int NE  = 3;
   localparam int DEB = 4;

`ifdef SINCRONIZADOR_PULSOS_EN
   localparam bit PULSOS = 1'b1;
`else
   localparam bit PULSOS = 1'b0;
`endif

   logic          clk;
   logic          reset;
   logic [NC-1:0] entrada;
   logic [NC-1:0] salida;
   logic [NC-1:0] sub;
   logic [NC-1:0] baj;

   int checks = 0;
   int errors = 0;

   sincronizador_antirrebote #(
      .N_CANALES       (NC),
      .N_ETAPAS        (NE),
      .DEBOUNCE_CICLOS (DEB)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .entrada_asincronica (entrada),
      .salida_estable      (salida),
      .pulso_subida        (sub),
      .pulso_bajada        (baj)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: the pin value seen by the debouncer is simply the
   // value sampled NE edges earlier. A level is accepted once it has
   // disagreed with the current output on DEB consecutive evaluations.
   logic [NC-1:0] pipe[$];
   logic [NC-1:0] m_est, m_sub, m_baj;
   int            run[NC];
   bit            m_ok = 1'b0;

   always @(posedge clk) begin
      logic [NC-1:0] cur;
      if (reset) begin
         pipe.delete();
         for (int k = 0; k < NE; k++) pipe.push_back('0);
         m_est = '0;
         m_sub = '0;
         m_baj = '0;
         for (int c = 0; c < NC; c++) run[c] = 0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         cur = pipe.pop_front();
         pipe.push_back(entrada);
         m_sub = '0;
         m_baj = '0;
         for (int c = 0; c < NC; c++) begin
            if (cur[c] != m_est[c]) begin
               run[c] = run[c] + 1;
               if (run[c] == DEB) begin
                  m_est[c] = cur[c];
                  if (PULSOS) begin
                     if (cur[c]) m_sub[c] = 1'b1;
                     else        m_baj[c] = 1'b1;
                  end
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
         end
      end
   end

   // Every-cycle comparison against the model, plus a counter of
   // pulso_bajada[1] occurrences.
   int cnt_baj1 = 0;
   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_salida", salida, m_est);
         chk("model_subida", sub, m_sub);
         chk("model_bajada", baj, m_baj);
         if (baj[1] === 1'b1) cnt_baj1++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Watchdog.
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      reset   = 1'b1;
      entrada = 4'hF;

      // Test 1: reset with all inputs high, then release.
      tick(1);
      chk("t1_rst_salida", salida, 4'h0);
      chk("t1_rst_subida", sub, 4'h0);
      tick(1);
      chk("t1_rst_bajada", baj, 4'h0);
      reset = 1'b0;
      tick(6);                                    // edges E0..E5
      chk("t1_before_rise", salida, 4'h0);
      tick(1);                                    // edge E6
      chk("t1_rise", salida, 4'hF);
      chk("t1_pulse", sub, PULSOS ? 4'hF : 4'h0);
      tick(1);
      chk("t1_pulse_end", sub, 4'h0);

      // Test 2: a 3-cycle glitch is rejected, and a 4-cycle level is accepted.
      entrada = 4'hE;
      tick(10);
      chk("t2_ch0_low", salida, 4'hE);
      entrada[0] = 1'b1;
      tick(3);
      entrada[0] = 1'b0;
      tick(10);
      chk("t2_glitch_rejected", salida, 4'hE);
      entrada[0] = 1'b1;
      tick(4);
      entrada[0] = 1'b0;
      tick(3);
      chk("t2_accept", salida, 4'hF);
      chk("t2_accept_pulse", sub, PULSOS ? 4'h1 : 4'h0);
      tick(1);
      chk("t2_pulse_end", sub, 4'h0);
      tick(8);

      // Test 3: ch1 toggling every cycle holds the output, then a steady low
      // produces one fall.
      entrada  = 4'hE;
      cnt_baj1 = 0;
      for (int k = 0; k < 20; k++) begin
         entrada[1] = ~entrada[1];
         tick(1);
      end
      chk("t3_hold_high", 4'(salida[1]), 4'h1);
      entrada[1] = 1'b0;
      tick(12);
      chk("t3_fell", 4'(salida[1]), 4'h0);
      chk("t3_one_bajada", 4'(cnt_baj1), PULSOS ? 4'h1 : 4'h0);

      // Test 4: ch2 rises while ch3 falls on the same edge.
      entrada = 4'h8;
      tick(10);
      entrada = 4'h4;
      tick(7);
      chk("t4_salida", salida, 4'h4);
      chk("t4_subida", sub, PULSOS ? 4'h4 : 4'h0);
      chk("t4_bajada", baj, PULSOS ? 4'h8 : 4'h0);
      tick(1);
      chk("t4_pulses_end", sub | baj, 4'h0);

      // Test 5: reset mid-debounce (counter at 2) discards progress.
      entrada = 4'h5;
      tick(5);
      reset = 1'b1;
      tick(1);
      chk("t5_rst_salida", salida, 4'h0);
      chk("t5_rst_pulses", sub | baj, 4'h0);
      reset = 1'b0;
      tick(6);
      chk("t5_no_early_rise", salida, 4'h0);
      tick(1);
      chk("t5_rise", salida, 4'h5);
      chk("t5_pulse", sub, PULSOS ? 4'h5 : 4'h0);
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sincronizador_antirrebote
`default_nettype wire
